// File: rtl/pipe_pkg.sv
// Shared types for the parametrised pipeline-stage register: state encoding and
// occupancy width.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_BUSY  = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_t;

   localparam int unsigned OCC_W = 2;

   // Number of entries held in a given state.
   function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
      logic [OCC_W-1:0] occ;
      occ = '0;
      case (s)
         PS_BUSY: occ = 2'd1;
         PS_FULL: occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Load-enable storage register for one pipeline entry (control + data bundle),
// cleared to zero by the asynchronous active-low reset.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int unsigned W = 72
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else if (load) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, synchronous flush
// and an optional skid entry that makes in_ready a decode of registered state.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 8,
   parameter bit          SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   localparam int unsigned W = CTRL_W + DATA_W;

   pipe_state_t      state_q, state_d;
   logic [OCC_W-1:0] occ_q;
   logic             in_fire, out_fire;
   logic             main_load, skid_load;
   logic [W-1:0]     in_bundle, main_d, main_q, skid_q;

   assign in_bundle = {in_ctrl, in_data};
   assign out_valid = (state_q != PS_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   generate
      if (SKID) begin : g_in_ready_reg
         assign in_ready = (state_q != PS_FULL);
      end else begin : g_in_ready_comb
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = in_bundle;
      // Flush wins: entries are dropped, but a transfer in this cycle still handshakes.
      if (flush) begin
         state_d = PS_EMPTY;
      end else begin
         unique case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  state_d   = PS_BUSY;
                  main_load = 1'b1;
               end
            end
            PS_BUSY: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  if (SKID) begin
                     state_d   = PS_FULL;
                     skid_load = 1'b1;
                  end
               end else if (out_fire) begin
                  state_d = PS_EMPTY;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  state_d   = PS_BUSY;
                  main_load = 1'b1;
                  main_d    = skid_q;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PS_EMPTY;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_of(state_d);
      end
   end

   pipe_entry_reg #(
      .W(W)
   ) u_main (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (main_load),
      .d      (main_d),
      .q      (main_q)
   );

   generate
      if (SKID) begin : g_skid
         pipe_entry_reg #(
            .W(W)
         ) u_skid (
            .clk    (clk),
            .reset_n(reset_n),
            .load   (skid_load),
            .d      (in_bundle),
            .q      (skid_q)
         );
      end else begin : g_no_skid
         logic unused_skid_load;
         assign unused_skid_load = skid_load;
         assign skid_q           = '0;
      end
   endgenerate

   // An empty stage must never present live control bits downstream.
   assign out_ctrl  = out_valid ? main_q[W-1:DATA_W] : '0;
   assign out_data  = main_q[DATA_W-1:0];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: instance a is the skid build, instance b the
// single-entry build; per-instance monitors compare delivered entries in order.
module tb_pipe_stage_reg;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int W  = DW + CW;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [CW-1:0] a_in_ctrl, a_out_ctrl;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [1:0]    a_occ;
   logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [CW-1:0] b_in_ctrl, b_out_ctrl;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [1:0]    b_occ;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
      .out_data(a_out_data), .occupancy(a_occ)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
      .out_data(b_out_data), .occupancy(b_occ)
   );

   int checks = 0;
   int errors = 0;
   int pops_a = 0;
   int pops_b = 0;
   int pushes_b = 0;
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected entries are pushed when an input handshake is issued and popped on delivery.
   always @(negedge clk) begin
      if (!reset_n) begin
         qa.delete();
      end else begin
         if (!a_out_valid) check("a_bubble_ctrl", W'(a_out_ctrl), '0);
         if (a_out_valid && a_out_ready) begin
            pops_a++;
            if (qa.size() == 0) check("a_unexpected_out", {a_out_ctrl, a_out_data}, '0);
            else check("a_order", {a_out_ctrl, a_out_data}, qa.pop_front());
         end
         if (a_flush) qa.delete();
         else if (a_in_valid && a_in_ready) qa.push_back({a_in_ctrl, a_in_data});
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         qb.delete();
      end else begin
         if (!b_out_valid) check("b_bubble_ctrl", W'(b_out_ctrl), '0);
         if (b_out_valid && b_out_ready) begin
            pops_b++;
            if (qb.size() == 0) check("b_unexpected_out", {b_out_ctrl, b_out_data}, '0);
            else check("b_order", {b_out_ctrl, b_out_data}, qb.pop_front());
         end
         if (b_flush) qb.delete();
         else if (b_in_valid && b_in_ready) begin
            qb.push_back({b_in_ctrl, b_in_data});
            pushes_b++;
         end
      end
   end

   initial begin
      int p0, u0, nxt;
      a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_in_ctrl = '0; a_in_data = '0;
      b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_in_ctrl = '0; b_in_data = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("a_reset_occ", W'(a_occ), 0);
      check("b_reset_in_ready", W'(b_in_ready), 1);

      // Fill the skid build, then assert reset mid-cycle.
      a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 8'h81;
      a_in_data = 64'h55; step();
      a_in_data = 64'h66; step();
      a_in_valid = 0;
      check("full_occ", W'(a_occ), 2);
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", W'(a_out_valid), 0);
      check("rst_out_ctrl", W'(a_out_ctrl), 0);
      check("rst_out_data", W'(a_out_data), 0);
      check("rst_occ", W'(a_occ), 0);
      step();
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", W'(a_in_ready), 1);
      a_out_ready = 1;

      // Streaming 0x01..0x10 back to back.
      p0 = pops_a;
      for (int i = 1; i <= 16; i++) begin
         a_in_valid = 1; a_in_ctrl = 8'h81; a_in_data = 64'(i);
         #1;
         check("stream_in_ready", W'(a_in_ready), 1);
         check("stream_out_valid", W'(a_out_valid), (i > 1) ? 1 : 0);
         step();
      end
      a_in_valid = 0;
      step();
      check("stream_count", W'(pops_a - p0), 16);
      check("stream_drained", W'(a_out_valid), 0);

      // Backpressure fills main and skid.
      a_out_ready = 0; a_in_valid = 1;
      a_in_data = 64'hAA; step();
      a_in_data = 64'hBB; step();
      a_in_valid = 0;
      check("bp_occ", W'(a_occ), 2);
      check("bp_in_ready", W'(a_in_ready), 0);
      check("bp_head", W'(a_out_data), 64'hAA);
      step();
      check("bp_hold_data", W'(a_out_data), 64'hAA);
      check("bp_hold_ctrl", W'(a_out_ctrl), 8'h81);
      p0 = pops_a;
      a_out_ready = 1;
      step(); step();
      check("bp_count", W'(pops_a - p0), 2);
      check("bp_queue_empty", W'(qa.size()), 0);
      check("bp_occ_after", W'(a_occ), 0);

      // Flush while full with a pending input.
      a_out_ready = 0; a_in_valid = 1;
      a_in_data = 64'hDD; step();
      a_in_data = 64'hEE; step();
      a_in_data = 64'hCC; a_flush = 1; step();
      a_flush = 0; a_in_valid = 0;
      check("fl_out_valid", W'(a_out_valid), 0);
      check("fl_out_ctrl", W'(a_out_ctrl), 0);
      check("fl_occ", W'(a_occ), 0);
      check("fl_in_ready", W'(a_in_ready), 1);
      check("fl_data_hold", W'(a_out_data), 64'hDD);
      p0 = pops_a;
      a_out_ready = 1;
      repeat (3) step();
      check("fl_no_output", W'(pops_a - p0), 0);

      // Single-entry build: combinational in_ready under a 1010 out_ready pattern.
      b_out_ready = 0; b_in_valid = 1; b_in_ctrl = 8'h42; b_in_data = 64'h11;
      step();
      b_in_data = 64'h22;
      #1;
      check("b_stall_in_ready", W'(b_in_ready), 0);
      p0 = pops_b; u0 = pushes_b; nxt = 'h22;
      for (int k = 0; k < 4; k++) begin
         b_out_ready = (k % 2 == 0);
         b_in_data = 64'(nxt);
         #1;
         if (b_in_ready) nxt++;
         step();
      end
      b_in_valid = 0;
      check("b_pattern_out", W'(pops_b - p0), 2);
      check("b_pattern_in", W'(pushes_b - u0), 2);
      b_out_ready = 1;
      step(); step();
      check("b_queue_empty", W'(qb.size()), 0);
      check("b_occ", W'(b_occ), 0);

      // Random traffic on both builds with occasional flush.
      for (int c = 0; c < 10000; c++) begin
         a_in_valid = 1'($urandom_range(0, 1)); a_out_ready = ($urandom_range(0, 3) != 0);
         a_flush = ($urandom_range(0, 99) < 2); a_in_ctrl = 8'($urandom);
         a_in_data = {$urandom, $urandom};
         b_in_valid = 1'($urandom_range(0, 1)); b_out_ready = ($urandom_range(0, 3) != 0);
         b_flush = ($urandom_range(0, 99) < 2); b_in_ctrl = 8'($urandom);
         b_in_data = {$urandom, $urandom};
         step();
      end
      a_in_valid = 0; a_flush = 0; a_out_ready = 1;
      b_in_valid = 0; b_flush = 0; b_out_ready = 1;
      repeat (4) step();
      check("rand_a_drained", W'(qa.size()), 0);
      check("rand_b_drained", W'(qb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
